// File: rtl/ble_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// ble_uart_tx_types_pkg
// Shared types and constants for the BLE UART transmitter slice.
//   uart_tx_state_t : serialiser FSM state set
//   UART_FRAME_BITS : start + data + stop bits in one 8N1 frame
//   UART_DATA_BITS  : payload width of one character
// ---------------------------------------------------------------------------
package ble_uart_tx_types_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } uart_tx_state_t;

  localparam int UART_FRAME_BITS = 10;
  localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/ble_uart_tx_if.sv
// ---------------------------------------------------------------------------
// ble_uart_tx_if
// Character stream from the setup FSM / BLE data path into the UART
// transmitter, plus the status and serial line coming back out.
//   byte_ready : write strobe (master -> slave)
//   cmd_byte   : character to send (master -> slave)
//   tx_full    : FIFO full, back-pressure (slave -> master)
//   tx_done    : one-cycle pulse at the end of each stop bit
//   tx_busy    : serialiser active or characters still queued
//   tx_drop    : one-cycle pulse when a write was discarded
//   fifo_count : current FIFO occupancy
//   tx         : serial line, idle high
// ---------------------------------------------------------------------------
interface ble_uart_tx_if #(
  parameter int FIFO_DEPTH = 16
);
  import ble_uart_tx_types_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                      byte_ready;
  logic [UART_DATA_BITS-1:0] cmd_byte;
  logic                      tx_full;
  logic                      tx_done;
  logic                      tx_busy;
  logic                      tx_drop;
  logic [CW-1:0]             fifo_count;
  logic                      tx;

  modport master (
    output byte_ready, cmd_byte,
    input  tx_full, tx_done, tx_busy, tx_drop, fifo_count, tx
  );

  modport slave (
    input  byte_ready, cmd_byte,
    output tx_full, tx_done, tx_busy, tx_drop, fifo_count, tx
  );

endinterface

// File: rtl/ble_uart_tx_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word fall-through FIFO. rd_data always presents the
// head entry, so a reader may consume it in the same cycle it raises rd_en.
// A write while full is accepted only when a read frees a slot that cycle.
//   clk, rst_n : clock, asynchronous active-low reset (flushes the FIFO)
//   wr_en      : push wr_data
//   rd_en      : pop the head entry (ignored when empty)
//   rd_data    : head entry
//   count      : registered occupancy
//   full/empty : registered status flags
// ---------------------------------------------------------------------------
module sync_fifo
  import ble_uart_tx_types_pkg::*;
#(
  parameter int WIDTH = UART_DATA_BITS,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             rd_ok_s;
  logic             wr_ok_s;

  // Qualify read/write; a full FIFO still takes a write if a slot frees now.
  always_comb begin
    rd_ok_s = rd_en && !empty_q;
    wr_ok_s = wr_en && (!full_q || rd_ok_s);
  end

  // Next-state pointers, occupancy and flags; pointers wrap at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == COUNT_FULL);
    empty_d = (count_d == {CW{1'b0}});
  end

  // Storage array; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/ble_uart_tx.sv
// ---------------------------------------------------------------------------
// ble_uart_tx
// FIFO-buffered 8N1 UART transmitter, LSB first, line idle high.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset; aborts any frame, flushes FIFO
//   bus   : ble_uart_tx_if slave (byte_ready/cmd_byte in; tx_full, tx_done,
//           tx_busy, tx_drop, fifo_count, tx out)
// Parameters: FIFO_DEPTH (power of 2, >= 2), BAUD_DIV (clocks per bit, >= 2).
// ---------------------------------------------------------------------------
module ble_uart_tx
  import ble_uart_tx_types_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_DIV   = 5208
) (
  input  logic         clk,
  input  logic         rst_n,
  ble_uart_tx_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  localparam logic [1:0] ST_IDLE  = TX_IDLE;
  localparam logic [1:0] ST_START = TX_START;
  localparam logic [1:0] ST_DATA  = TX_DATA;
  localparam logic [1:0] ST_STOP  = TX_STOP;

  logic [1:0]                state_q, state_d;
  logic [BW-1:0]             baud_q, baud_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      done_q, done_d;
  logic                      drop_q, drop_d;
  logic                      busy_q, busy_d;

  logic [UART_DATA_BITS-1:0] fifo_rd_data_s;
  logic [CW-1:0]             fifo_count_s;
  logic                      fifo_full_s;
  logic                      fifo_empty_s;
  logic                      pop_s;
  logic                      wr_ok_s;
  logic                      baud_last_s;
  logic [CW-1:0]             count_next_s;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bus.byte_ready),
    .wr_data (bus.cmd_byte),
    .rd_en   (pop_s),
    .rd_data (fifo_rd_data_s),
    .count   (fifo_count_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Pop only from idle; mirror the FIFO's accept rule to predict occupancy
  // so that tx_busy can be registered alongside fifo_count.
  always_comb begin
    pop_s        = (state_q == ST_IDLE) && !fifo_empty_s;
    wr_ok_s      = bus.byte_ready && (!fifo_full_s || pop_s);
    baud_last_s  = (baud_q == BAUD_LAST);
    count_next_s = fifo_count_s + {{(CW-1){1'b0}}, wr_ok_s}
                                - {{(CW-1){1'b0}}, pop_s};
  end

  // Serialiser FSM: start bit, eight data bits LSB first, stop bit.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (pop_s) begin
          shift_d = fifo_rd_data_s;
          tx_d    = 1'b0;
          baud_d  = {BW{1'b0}};
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_last_s) begin
          tx_d    = shift_q[0];
          bit_d   = 3'd0;
          baud_d  = {BW{1'b0}};
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_last_s) begin
          baud_d = {BW{1'b0}};
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            // Next bit to drive is the one that lands in position 0 after the shift.
            shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_last_s) begin
          baud_d  = {BW{1'b0}};
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = {BW{1'b0}};
        bit_d   = 3'd0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Status pulses and busy flag, computed from post-edge state.
  always_comb begin
    drop_d = bus.byte_ready && fifo_full_s && !pop_s;
    busy_d = (state_d != ST_IDLE) || (count_next_s != {CW{1'b0}});
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= {BW{1'b0}};
      bit_q   <= 3'd0;
      shift_q <= {UART_DATA_BITS{1'b0}};
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.tx_done    = done_q;
  assign bus.tx_drop    = drop_q;
  assign bus.tx_busy    = busy_q;
  assign bus.tx_full    = fifo_full_s;
  assign bus.fifo_count = fifo_count_s;

endmodule

// File: tb/tb_ble_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_ble_uart_tx
// Directed and randomized stimulus for ble_uart_tx (BAUD_DIV=4, depth 4),
// compared every cycle against a frame-timing reference model: a queue of
// pending characters plus the elapsed time inside the frame on the line.
// ---------------------------------------------------------------------------
module tb_ble_uart_tx;
  import ble_uart_tx_types_pkg::*;

  localparam int BD        = 4;
  localparam int DEPTH     = 4;
  localparam int FRAME_CYC = UART_FRAME_BITS * BD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ble_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ble_uart_tx #(
    .FIFO_DEPTH (DEPTH),
    .BAUD_DIV   (BD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0] mq[$];
  bit         m_active;
  int         m_t;
  logic [7:0] m_cur;
  bit         m_done;
  bit         m_drop;
  bit         m_popped;

  // observations of the DUT
  int cyc;
  int obs_done;
  int obs_drop;
  int obs_full;
  int peak_count;
  int last_done_cyc;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_active = 1'b0;
    m_t      = 0;
    m_cur    = 8'h00;
    m_done   = 1'b0;
    m_drop   = 1'b0;
    m_popped = 1'b0;
  endtask

  // Line level expected for the current time within a frame.
  function automatic logic exp_tx();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_t / BD;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_cur[idx-1];
    return 1'b1;
  endfunction

  task automatic model_step(input bit br, input logic [7:0] d);
    bit full;
    bit pop;
    full     = (mq.size() == DEPTH);
    pop      = !m_active && (mq.size() > 0);
    m_popped = pop;
    m_done   = 1'b0;
    m_drop   = 1'b0;
    if (m_active) begin
      if (m_t == FRAME_CYC - 1) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end else begin
        m_t++;
      end
    end
    if (pop) begin
      m_cur    = mq.pop_front();
      m_active = 1'b1;
      m_t      = 0;
    end
    if (br) begin
      if (!full || pop) mq.push_back(d);
      else m_drop = 1'b1;
    end
  endtask

  task automatic check_outputs();
    check_val("tx",    32'(bus.tx),         32'(exp_tx()));
    check_val("count", 32'(bus.fifo_count), 32'(mq.size()));
    check_val("full",  32'(bus.tx_full),    32'(mq.size() == DEPTH));
    check_val("busy",  32'(bus.tx_busy),    32'(m_active || (mq.size() > 0)));
    check_val("done",  32'(bus.tx_done),    32'(m_done));
    check_val("drop",  32'(bus.tx_drop),    32'(m_drop));
  endtask

  task automatic cycle(input bit br, input logic [7:0] d);
    bus.byte_ready = br;
    bus.cmd_byte   = d;
    @(posedge clk);
    model_step(br, d);
    cyc++;
    @(negedge clk);
    check_outputs();
    if (bus.tx_done === 1'b1) begin
      obs_done++;
      last_done_cyc = cyc;
    end
    if (bus.tx_drop === 1'b1) obs_drop++;
    if (bus.tx_full === 1'b1) obs_full++;
    if (int'(bus.fifo_count) > peak_count) peak_count = int'(bus.fifo_count);
  endtask

  task automatic clear_obs();
    obs_done   = 0;
    obs_drop   = 0;
    obs_full   = 0;
    peak_count = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && (m_active || mq.size() > 0); i++) cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
  endtask

  initial begin
    int wcyc;
    logic [7:0] at_str [4];
    at_str[0] = 8'h41; at_str[1] = 8'h54; at_str[2] = 8'h0D; at_str[3] = 8'h0A;
    bus.byte_ready = 1'b0;
    bus.cmd_byte   = 8'h00;
    cyc = 0;
    last_done_cyc = -1;
    model_reset();
    clear_obs();

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // single 0x41, done 41 cycles after the write edge
    clear_obs();
    cycle(1'b1, 8'h41);
    wcyc = cyc;
    drain();
    check_val("single_done_cnt", 32'(obs_done), 32'd1);
    check_val("single_done_lat", 32'(last_done_cyc - wcyc), 32'(FRAME_CYC + 1));

    // "AT\r\n" on consecutive cycles
    clear_obs();
    for (int i = 0; i < 4; i++) cycle(1'b1, at_str[i]);
    drain();
    check_val("at_peak", 32'(peak_count), 32'd3);
    check_val("at_done_cnt", 32'(obs_done), 32'd4);

    // six writes: last one dropped
    clear_obs();
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(i));
    drain();
    check_val("six_drop_cnt", 32'(obs_drop), 32'd1);
    check_val("six_full_seen", 32'(obs_full > 0), 32'd1);

    // hold writes while full across the idle pop
    clear_obs();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom_range(0, 255)));
    for (int i = 0; i < FRAME_CYC + 6; i++) begin
      cycle(1'b1, 8'($urandom_range(0, 255)));
      if (m_popped) begin
        check_val("wf_pop_count", 32'(bus.fifo_count), 32'd4);
        check_val("wf_pop_drop",  32'(bus.tx_drop),    32'd0);
      end
    end
    drain();

    // reset during data bit 3 with another byte queued
    clear_obs();
    cycle(1'b1, 8'hA5);
    cycle(1'b1, 8'h3C);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00);
    check_val("pre_rst_bit3", 32'(m_t / BD), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_tx",    32'(bus.tx),         32'd1);
    check_val("rst_count", 32'(bus.fifo_count), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    for (int i = 0; i < FRAME_CYC + 10; i++) cycle(1'b0, 8'h00);
    check_val("rst_no_done", 32'(obs_done), 32'd0);

    // 0xFF: only the start bit is low
    clear_obs();
    cycle(1'b1, 8'hFF);
    drain();
    check_val("ff_drop", 32'(obs_drop), 32'd0);
    check_val("ff_full", 32'(obs_full), 32'd0);
    check_val("ff_done", 32'(obs_done), 32'd1);

    // randomized traffic at several write densities
    for (int r = 0; r < 4; r++) begin
      int pct;
      pct = (r == 0) ? 5 : (r == 1) ? 30 : (r == 2) ? 70 : 100;
      for (int i = 0; i < 700; i++) begin
        cycle(($urandom_range(0, 99) < pct), 8'($urandom_range(0, 255)));
      end
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ble_uart_tx.md
# ble_uart_tx

Byte-oriented UART transmitter with an input FIFO. It sits directly downstream of `ble_setup` and of any later BLE data path. It accepts AT-command characters on a one-cycle `byte_ready` strobe and serialises them 8N1, LSB first, onto the line to the BLE module. It returns `tx_full` for back-pressure and a per-character `tx_done` pulse, which the setup FSM uses to restart its acknowledge timer.

## Interface
Parameters:
- `FIFO_DEPTH`, default 16: FIFO entries. Must be a power of 2 and ≥ 2.
- `BAUD_DIV`, default 5208: clock cycles per bit. 50 MHz / 9600 baud. Must be ≥ 2.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `byte_ready`  in  1  write strobe; pushes `cmd_byte` into the FIFO.
- `cmd_byte`  in  8  character to send.
- `tx_full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `tx_done`  out  1  one-cycle pulse when a frame's stop bit completes.
- `tx_busy`  out  1  serialiser is not in TX_IDLE, or the FIFO is non-empty.
- `tx_drop`  out  1  one-cycle pulse when a write was discarded.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `tx`  out  1  serial line; idle level is high.

## Operation
- Reset values: `tx`=1, `tx_done`=0, `tx_full`=0, `tx_busy`=0, `tx_drop`=0, `fifo_count`=0. The FIFO is empty, the FSM is in TX_IDLE, and all counters are 0.
- Reset mid-frame aborts the frame immediately and flushes the FIFO. `tx` returns high asynchronously.
- FIFO write happens when `byte_ready`=1 and the FIFO is not full.
  - A write while full is discarded, and `tx_drop` pulses on the next cycle.
  - Exception: if a pop happens in the same cycle as a write while full, the write is accepted and the count is unchanged.
- FIFO read (pop) happens only in TX_IDLE when `fifo_count`≠0. The popped byte is loaded into an 8-bit shift register.
- A write and a pop in the same cycle leave `fifo_count` unchanged. Read and write pointers wrap modulo `FIFO_DEPTH`.
- FSM states and transitions:
  - TX_IDLE: `tx`=1. If the FIFO is non-empty: pop, load the shift register, set `tx`←0, clear the baud counter, go to TX_START.
  - TX_START: hold `tx`=0 for `BAUD_DIV` cycles. Then `tx`←shift[0], bit counter←0, go to TX_DATA.
  - TX_DATA: each bit lasts `BAUD_DIV` cycles. At the end of each bit, shift right and increment the bit counter. After bit 7, `tx`←1 and go to TX_STOP.
  - TX_STOP: hold `tx`=1 for `BAUD_DIV` cycles. On the last cycle, go to TX_IDLE and set `tx_done`←1 for one cycle.
- Baud counter: width $clog2(`BAUD_DIV`). It counts 0..`BAUD_DIV`-1, and the bit boundary is at `BAUD_DIV`-1. The bit counter is 3 bits wide.
- `cmd_byte` is sampled only on the write edge. Changes while queued have no effect.

## Timing
- Write-to-line latency: with the FIFO empty and the FSM in TX_IDLE, a write sampled at edge E0 gives `fifo_count`=1 after E0. The pop happens at E1, and `tx` goes low after E1.
- Frame duration:
  - start 1 bit + data 8 bits + stop 1 bit = 10×`BAUD_DIV` cycles;
  - plus 1 TX_IDLE cycle between back-to-back frames, so the frame period is 10×`BAUD_DIV`+1.
- `tx_done` is asserted in the cycle the FSM re-enters TX_IDLE. It is coincident with the pop of the next byte, if one is queued.
- `tx_full`, `fifo_count` and `tx_busy` are registered and reflect the state after the current edge. The upstream block must not write in the cycle after `tx_full` is sampled high.
- `tx` is driven from a flop, so the line is glitch-free.

## Structure
- Package `ble_uart_tx_types_pkg` contains:
  - `uart_tx_state_t`, an enum {TX_IDLE, TX_START, TX_DATA, TX_STOP};
  - localparam `UART_FRAME_BITS`=10.
- Sub-module `sync_fifo` (parameters WIDTH=8, DEPTH):
  - ports: `wr_en`, `wr_data`, `rd_en`, `rd_data`, `count`, `full`, `empty`;
  - read data is valid in the same cycle as `rd_en` (first-word fall-through).
- The top level holds the FSM, the baud and bit counters, the shift register, and the drop and done pulse logic.

## Test plan
All directed tests run with `BAUD_DIV`=4 and `FIFO_DEPTH`=4.
- Single write of 0x41 → `tx` sequence is 0,1,0,0,0,0,0,1,0,1, each bit 4 cycles. `tx_done` is a single pulse 41 cycles after the write edge.
- Writes of "AT\r\n" on 4 consecutive cycles:
  - `fifo_count` peaks at 3, because the first byte is popped at E1;
  - frames are back-to-back with a 41-cycle period;
  - `tx_done` pulses 4 times.
- 6 consecutive writes of 0x00..0x05 → `tx_full` goes high. `tx_drop` pulses for byte 0x05 only. The line carries 0x00..0x04.
- Write while full in the same cycle as the TX_IDLE pop → the write is accepted, `fifo_count` stays 4, and there is no `tx_drop`.
- `rst_n` asserted during data bit 3 → `tx`=1 asynchronously and `fifo_count`=0. After release there is no `tx_done` and the line stays idle.
- Write 0xFF → the line is low only during the start bit, with no spurious `tx_drop` or `tx_full`.
